// File: rtl/satd_block_assembler.sv
// rtl/satd_block_assembler.sv - collects pixel-pair beats into ORG/CUR blocks for the SATD core
// A block closes on beat NPIX-1 or on in_last; early closes are zero-filled and flagged via err_short.
module satd_block_assembler #(
    parameter int PIX_W = 8,
    parameter int NPIX  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [PIX_W-1:0]      in_org,
    input  logic [PIX_W-1:0]      in_cur,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIX_W*NPIX-1:0] ORG,
    output logic [PIX_W*NPIX-1:0] CUR,
    output logic                  err_short
);

    localparam int              CW       = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int              BW       = PIX_W * NPIX;
    localparam logic [CW-1:0]   LAST_IDX = CW'(NPIX - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   org_buf_q, org_buf_d;
    logic [BW-1:0]   cur_buf_q, cur_buf_d;
    logic [BW-1:0]   org_q, org_d;
    logic [BW-1:0]   cur_q, cur_d;
    logic            out_valid_q, out_valid_d;
    logic            err_q, err_d;

    logic            accept;
    logic            take;
    logic            slot_free;
    logic            closing;
    int              pix_idx;

    assign in_ready  = (state_q == FILL) && !rst;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid_q && out_ready;
    assign slot_free = !out_valid_q || out_ready;
    assign closing   = accept && ((count_q == LAST_IDX) || in_last);
    assign pix_idx   = int'(count_q);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        org_buf_d   = org_buf_q;
        cur_buf_d   = cur_buf_q;
        org_d       = org_q;
        cur_d       = cur_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        // A take with nothing loaded empties the slot; a load below overrides this.
        if (take) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    org_buf_d[pix_idx*PIX_W +: PIX_W] = in_org;
                    cur_buf_d[pix_idx*PIX_W +: PIX_W] = in_cur;
                    if (closing) begin
                        count_d = '0;
                        err_d   = (count_q != LAST_IDX);
                        if (slot_free) begin
                            org_d       = org_buf_d;
                            cur_d       = cur_buf_d;
                            out_valid_d = 1'b1;
                            org_buf_d   = '0;
                            cur_buf_d   = '0;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                // The buffer was left zero-filled above the last pixel, so it is the finished block.
                if (take) begin
                    org_d       = org_buf_q;
                    cur_d       = cur_buf_q;
                    out_valid_d = 1'b1;
                    org_buf_d   = '0;
                    cur_buf_d   = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            count_q     <= '0;
            org_buf_q   <= '0;
            cur_buf_q   <= '0;
            org_q       <= '0;
            cur_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            org_buf_q   <= org_buf_d;
            cur_buf_q   <= cur_buf_d;
            org_q       <= org_d;
            cur_q       <= cur_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ORG       = org_q;
    assign CUR       = cur_q;
    assign err_short = err_q;

endmodule

// File: tb/tb_satd_block_assembler.sv
// tb/tb_satd_block_assembler.sv - directed table, hold/reset sequences and a stalled-traffic scoreboard
module tb_satd_block_assembler;

    localparam int PW = 8;
    localparam int NP = 128;
    localparam int BW = PW * NP;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [PW-1:0] in_org;
    logic [PW-1:0] in_cur;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] ORG;
    logic [BW-1:0] CUR;
    logic          err_short;

    satd_block_assembler #(.PIX_W(PW), .NPIX(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_org    (in_org),
        .in_cur    (in_cur),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ORG       (ORG),
        .CUR       (CUR),
        .err_short (err_short)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        int fb;
        fb = -1;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int i = NP - 1; i >= 0; i--)
                if (act[i*PW +: PW] !== exp[i*PW +: PW]) fb = i;
            $display("FAIL %s: first bad byte %0d got %02h expected %02h",
                     name, fb, act[fb*PW +: PW], exp[fb*PW +: PW]);
        end
    endtask

    typedef struct {
        int         len;
        bit         last;
        logic [7:0] org_base;
        logic [7:0] cur_base;
        bit         step;
        int         pa;
        logic [7:0] ea_org;
        logic [7:0] ea_cur;
        int         pb;
        logic [7:0] eb_org;
        logic [7:0] eb_cur;
        bit         exp_err;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] px_org(input vec_t v, input int k);
        return v.org_base + (v.step ? 8'(k) : 8'd0);
    endfunction

    function automatic logic [7:0] px_cur(input vec_t v, input int k);
        return v.cur_base - (v.step ? 8'(k) : 8'd0);
    endfunction

    function automatic logic [BW-1:0] mk_bus(input vec_t v, input bit is_cur);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < v.len; k++)
            b[k*PW +: PW] = is_cur ? px_cur(v, k) : px_org(v, k);
        return b;
    endfunction

    function automatic logic [BW-1:0] ramp_bus(input logic [7:0] base, input bit down);
        logic [BW-1:0] b;
        for (int k = 0; k < NP; k++)
            b[k*PW +: PW] = down ? base - 8'(k) : base + 8'(k);
        return b;
    endfunction

    logic [BW-1:0] q_org[$];
    logic [BW-1:0] q_cur[$];
    logic [BW-1:0] bld_org, bld_cur, prev_org, prev_cur;

    initial begin
        vec_t v;
        int   rdy_bad, vbad, stab_bad, unexp;
        int   k_pix, blk_len, sent, got, cyc;
        bit   prev_hold;
        bit   last_rand;

        vecs[0] = '{128, 1'b0, 8'h00, 8'hFF, 1'b1,   0, 8'h00, 8'hFF, 127, 8'h7F, 8'h80, 1'b0};
        vecs[1] = '{128, 1'b1, 8'h10, 8'h20, 1'b1,   5, 8'h15, 8'h1B, 127, 8'h8F, 8'hA1, 1'b0};
        vecs[2] = '{ 10, 1'b1, 8'hAA, 8'h55, 1'b0,   9, 8'hAA, 8'h55,  10, 8'h00, 8'h00, 1'b1};
        vecs[3] = '{  1, 1'b1, 8'h3C, 8'hC3, 1'b1,   0, 8'h3C, 8'hC3,   1, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{127, 1'b1, 8'h80, 8'h7F, 1'b1, 126, 8'hFE, 8'h01, 127, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{128, 1'b0, 8'hFF, 8'h00, 1'b1,   1, 8'h00, 8'hFF,  64, 8'h3F, 8'hC0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_org = '0; in_cur = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_err", err_short, 0);
        chk_bus("rst_org", ORG, '0);
        chk_bus("rst_cur", CUR, '0);
        rst = 1'b0;
        #1 chk("ready_after_rst", in_ready, 1);

        // Directed table: one block per record, out_ready held high.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            rdy_bad = 0;
            for (int k = 0; k < v.len; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_org   = px_org(v, k);
                in_cur   = px_cur(v, k);
                in_last  = v.last && (k == v.len - 1);
                if (!in_ready) rdy_bad++;
            end
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
            chk($sformatf("v%0d_ready", i), rdy_bad, 0);
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_err", i), err_short, v.exp_err);
            chk($sformatf("v%0d_org_a", i), ORG[v.pa*PW +: PW], v.ea_org);
            chk($sformatf("v%0d_cur_a", i), CUR[v.pa*PW +: PW], v.ea_cur);
            chk($sformatf("v%0d_org_b", i), ORG[v.pb*PW +: PW], v.eb_org);
            chk($sformatf("v%0d_cur_b", i), CUR[v.pb*PW +: PW], v.eb_cur);
            chk_bus($sformatf("v%0d_org_bus", i), ORG, mk_bus(v, 1'b0));
            chk_bus($sformatf("v%0d_cur_bus", i), CUR, mk_bus(v, 1'b1));
            @(negedge clk);
            chk($sformatf("v%0d_err_gone", i), err_short, 0);
            chk($sformatf("v%0d_drained", i), out_valid, 0);
        end

        // Two blocks back-to-back with the output stalled: second one waits in HOLD.
        out_ready = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < NP; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_org   = (b == 0) ? 8'(k + 1) : 8'(8'h40 + k);
                in_cur   = (b == 0) ? 8'(8'hF0 - k) : 8'(8'h90 - k);
                in_last  = 1'b0;
            end
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            in_valid = 1'b1; in_org = 8'hEE; in_cur = 8'hEE; in_last = 1'b1;
            chk($sformatf("hold_in_ready_%0d", w), in_ready, 0);
            chk($sformatf("hold_out_valid_%0d", w), out_valid, 1);
            chk_bus($sformatf("hold_org_a_%0d", w), ORG, ramp_bus(8'h01, 1'b0));
        end
        chk_bus("hold_cur_a", CUR, ramp_bus(8'hF0, 1'b1));
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handover_out_valid", out_valid, 1);
        chk("handover_in_ready", in_ready, 1);
        chk("handover_org_lo", ORG[7:0], 8'h40);
        chk("handover_org_hi", ORG[BW-1 -: 8], 8'hBF);
        chk_bus("handover_org", ORG, ramp_bus(8'h40, 1'b0));
        chk_bus("handover_cur", CUR, ramp_bus(8'h90, 1'b1));
        out_ready = 1'b1;
        @(negedge clk);
        chk("handover_drained", out_valid, 0);

        // Reset in the middle of a block discards the partial pixels.
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_org = 8'h11; in_cur = 8'h22; in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1 chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        vbad = 0;
        for (int k = 0; k < NP; k++) begin
            @(negedge clk);
            if (out_valid) vbad++;
            in_valid = 1'b1; in_org = 8'(k); in_cur = 8'(255 - k); in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_early_valid", vbad, 0);
        chk("midrst_out_valid", out_valid, 1);
        chk("midrst_org_lo", ORG[7:0], 8'h00);
        chk("midrst_org_hi", ORG[BW-1 -: 8], 8'h7F);
        chk("midrst_cur_lo", CUR[7:0], 8'hFF);
        chk_bus("midrst_org", ORG, ramp_bus(8'h00, 1'b0));
        chk_bus("midrst_cur", CUR, ramp_bus(8'hFF, 1'b1));
        @(negedge clk);

        // Randomised stalls on both sides against a scoreboard of expected blocks.
        stab_bad = 0; unexp = 0; sent = 0; got = 0; cyc = 0; k_pix = 0;
        prev_hold = 1'b0; prev_org = '0; prev_cur = '0;
        bld_org = '0; bld_cur = '0;
        blk_len = 128;
        while (!(sent == 50 && got == 50) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (prev_hold && (!out_valid || ORG !== prev_org || CUR !== prev_cur)) stab_bad++;
            out_ready = (sent == 50) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (q_org.size() == 0) unexp++;
                else begin
                    chk_bus($sformatf("rand_org_blk%0d", got), ORG, q_org.pop_front());
                    chk_bus($sformatf("rand_cur_blk%0d", got), CUR, q_cur.pop_front());
                end
                got++;
            end
            in_valid  = (sent < 50) && ($urandom_range(0, 3) != 0);
            in_org    = 8'($urandom);
            in_cur    = 8'($urandom);
            last_rand = 1'($urandom);
            if (in_valid)
                in_last = (k_pix == blk_len - 1) && (blk_len < NP || last_rand);
            else
                in_last = last_rand;
            if (in_valid && in_ready) begin
                bld_org[k_pix*PW +: PW] = in_org;
                bld_cur[k_pix*PW +: PW] = in_cur;
                k_pix++;
                if (k_pix == blk_len) begin
                    q_org.push_back(bld_org);
                    q_cur.push_back(bld_cur);
                    bld_org = '0; bld_cur = '0; k_pix = 0; sent++;
                    blk_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NP)) : NP;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_org  = ORG;
            prev_cur  = CUR;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("rand_blocks_sent", sent, 50);
        chk("rand_blocks_got", got, 50);
        chk("rand_unexpected", unexp, 0);
        chk("rand_leftover", q_org.size(), 0);
        chk("rand_stable", stab_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
